// File: rtl/therm_accum.sv
// Thermometer-word decoder and windowed accumulator with valid/ready result port.
// Optional THERM_ACCUM_STRICT_EN: bubbled words are flagged but neither summed nor counted.
module therm_accum #(
  parameter int unsigned WIN   = 16,
  parameter int unsigned ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_therm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_err,
  output logic             out_sat
);

  localparam int unsigned CNT_W = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]       state, state_n;
  logic [ACC_W-1:0] acc, acc_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             err, err_n;
  logic             sat, sat_n;
  logic             in_ready_n;
  logic             out_valid_n;
  logic [ACC_W-1:0] out_sum_n;
  logic             out_err_n;
  logic             out_sat_n;

  logic [3:0]       pop_c;
  logic             bubble_c;
  logic [3:0]       value_c;
  logic             counted_c;
  logic             accept_c;
  logic [SUM_W-1:0] sum_c;

  // A bubble is any 1 sitting directly below a 0.
  always_comb begin
    pop_c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      pop_c = pop_c + 4'(in_therm[i]);
    end
    bubble_c = |(in_therm[6:0] & ~in_therm[7:1]);
  end

`ifdef THERM_ACCUM_STRICT_EN
  assign counted_c = ~bubble_c;
  assign value_c   = bubble_c ? 4'd0 : pop_c;
`else
  assign counted_c = 1'b1;
  assign value_c   = pop_c;
`endif

  assign accept_c = in_valid & in_ready;
  // Extra top bit of the sum is the saturation indicator.
  assign sum_c    = {1'b0, acc} + SUM_W'(value_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      sat       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_err   <= 1'b0;
      out_sat   <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      err       <= err_n;
      sat       <= sat_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      out_sum   <= out_sum_n;
      out_err   <= out_err_n;
      out_sat   <= out_sat_n;
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_n     = state;
    acc_n       = acc;
    cnt_n       = cnt;
    err_n       = err;
    sat_n       = sat;
    in_ready_n  = in_ready;
    out_valid_n = out_valid;
    out_sum_n   = out_sum;
    out_err_n   = out_err;
    out_sat_n   = out_sat;

    case (state)
      IDLE, ACCUM: begin
        if (accept_c) begin
          err_n = err | bubble_c;
          if (counted_c) begin
            sat_n = sat | sum_c[ACC_W];
            acc_n = sum_c[ACC_W] ? ACC_MAX : sum_c[ACC_W-1:0];
            if (cnt == CNT_LAST) begin
              state_n     = HOLD;
              cnt_n       = '0;
              in_ready_n  = 1'b0;
              out_valid_n = 1'b1;
              out_sum_n   = acc_n;
              out_err_n   = err_n;
              out_sat_n   = sat_n;
            end else begin
              state_n = ACCUM;
              cnt_n   = cnt + CNT_W'(1);
            end
          end
        end
      end

      HOLD: begin
        if (out_ready) begin
          state_n     = IDLE;
          acc_n       = '0;
          cnt_n       = '0;
          err_n       = 1'b0;
          sat_n       = 1'b0;
          in_ready_n  = 1'b1;
          out_valid_n = 1'b0;
        end
      end

      default: begin
        state_n     = IDLE;
        acc_n       = '0;
        cnt_n       = '0;
        err_n       = 1'b0;
        sat_n       = 1'b0;
        in_ready_n  = 1'b1;
        out_valid_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_therm_accum.sv
// Directed bench for therm_accum: WIN=4 with ACC_W=8 (dut_a) and ACC_W=5 (dut_b) in lockstep.
module tb_therm_accum;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_therm;
  logic       out_ready;

  logic       in_ready_a, out_valid_a, out_err_a, out_sat_a;
  logic [7:0] out_sum_a;
  logic       in_ready_b, out_valid_b, out_err_b, out_sat_b;
  logic [4:0] out_sum_b;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  therm_accum #(.WIN(4), .ACC_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_therm(in_therm), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_sum(out_sum_a), .out_err(out_err_a), .out_sat(out_sat_a)
  );

  therm_accum #(.WIN(4), .ACC_W(5)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_therm(in_therm), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_sum(out_sum_b), .out_err(out_err_b), .out_sat(out_sat_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] w);
    in_valid = 1'b1;
    in_therm = w;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_therm = 8'h00;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; in_therm = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if ({out_valid_a, in_ready_a, out_err_a, out_sat_a, out_sum_a} !== {1'b0, 1'b1, 1'b0, 1'b0, 8'd0}) begin
        errors++;
        $display("FAIL reset_state: got v=%0b r=%0b e=%0b s=%0b sum=%0d want v=0 r=1 e=0 s=0 sum=0",
                 out_valid_a, in_ready_a, out_err_a, out_sat_a, out_sum_a);
      end
    end
    rst = 1'b0; in_valid = 1'b0; in_therm = 8'h00;
  endtask

  task automatic test_basic;
    logic [7:0] words [4];
    words[0] = 8'hF0; words[1] = 8'hF0; words[2] = 8'hFF; words[3] = 8'h80;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      put(words[i]);
      vectors++;
      if ({out_valid_a, in_ready_a, out_sum_a} !== {1'b0, 1'b1, 8'd0}) begin
        errors++;
        $display("FAIL basic_partial%0d: got v=%0b r=%0b sum=%0d want v=0 r=1 sum=0",
                 i, out_valid_a, in_ready_a, out_sum_a);
      end
    end
    put(words[3]);
    vectors++;
    if ({out_valid_a, in_ready_a, out_err_a, out_sat_a, out_sum_a} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd17}) begin
      errors++;
      $display("FAIL basic_result: got v=%0b r=%0b e=%0b s=%0b sum=%0d want v=1 r=0 e=0 s=0 sum=17",
               out_valid_a, in_ready_a, out_err_a, out_sat_a, out_sum_a);
    end
    tick();
    vectors++;
    if ({out_valid_a, in_ready_a, out_sum_a} !== {1'b0, 1'b1, 8'd17}) begin
      errors++;
      $display("FAIL basic_release: got v=%0b r=%0b sum=%0d want v=0 r=1 sum=17",
               out_valid_a, in_ready_a, out_sum_a);
    end
  endtask

  task automatic test_back_to_back;
    put(8'h80); put(8'hC0); put(8'hE0); put(8'hF0);
    vectors++;
    if ({out_valid_a, in_ready_a, out_err_a, out_sum_a} !== {1'b1, 1'b0, 1'b0, 8'd10}) begin
      errors++;
      $display("FAIL b2b_result: got v=%0b r=%0b e=%0b sum=%0d want v=1 r=0 e=0 sum=10",
               out_valid_a, in_ready_a, out_err_a, out_sum_a);
    end
    tick();
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    put(8'hC0); put(8'hE0); put(8'hFE); put(8'h00);
    in_valid = 1'b1; in_therm = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if ({out_valid_a, in_ready_a, out_err_a, out_sat_a, out_sum_a} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd12}) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%0b r=%0b e=%0b s=%0b sum=%0d want v=1 r=0 e=0 s=0 sum=12",
                 i, out_valid_a, in_ready_a, out_err_a, out_sat_a, out_sum_a);
      end
    end
    in_valid = 1'b0; in_therm = 8'h00; out_ready = 1'b1;
    tick();
    vectors++;
    if ({out_valid_a, in_ready_a} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release: got v=%0b r=%0b want v=0 r=1", out_valid_a, in_ready_a);
    end
  endtask

  task automatic test_bubble;
    out_ready = 1'b1;
    put(8'h80); put(8'hA0); put(8'h80); put(8'h80);
`ifdef THERM_ACCUM_STRICT_EN
    vectors++;
    if ({out_valid_a, in_ready_a} !== 2'b01) begin
      errors++;
      $display("FAIL bubble_strict_wait: got v=%0b r=%0b want v=0 r=1", out_valid_a, in_ready_a);
    end
    put(8'h80);
    vectors++;
    if ({out_valid_a, out_err_a, out_sum_a} !== {1'b1, 1'b1, 8'd4}) begin
      errors++;
      $display("FAIL bubble_strict_result: got v=%0b e=%0b sum=%0d want v=1 e=1 sum=4",
               out_valid_a, out_err_a, out_sum_a);
    end
    tick();
    put(8'h80); put(8'h80); put(8'h80); put(8'hA0);
    vectors++;
    if (out_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL bubble_last_strict_wait: got v=%0b want v=0", out_valid_a);
    end
    put(8'h80);
    vectors++;
    if ({out_valid_a, out_err_a, out_sum_a} !== {1'b1, 1'b1, 8'd4}) begin
      errors++;
      $display("FAIL bubble_last_strict: got v=%0b e=%0b sum=%0d want v=1 e=1 sum=4",
               out_valid_a, out_err_a, out_sum_a);
    end
    tick();
`else
    vectors++;
    if ({out_valid_a, out_err_a, out_sum_a} !== {1'b1, 1'b1, 8'd5}) begin
      errors++;
      $display("FAIL bubble_result: got v=%0b e=%0b sum=%0d want v=1 e=1 sum=5",
               out_valid_a, out_err_a, out_sum_a);
    end
    tick();
    vectors++;
    if ({out_valid_a, in_ready_a, out_err_a, out_sum_a} !== {1'b0, 1'b1, 1'b1, 8'd5}) begin
      errors++;
      $display("FAIL bubble_held: got v=%0b r=%0b e=%0b sum=%0d want v=0 r=1 e=1 sum=5",
               out_valid_a, in_ready_a, out_err_a, out_sum_a);
    end
    put(8'h80); put(8'h80); put(8'h80); put(8'hA0);
    vectors++;
    if ({out_valid_a, out_err_a, out_sum_a} !== {1'b1, 1'b1, 8'd5}) begin
      errors++;
      $display("FAIL bubble_last: got v=%0b e=%0b sum=%0d want v=1 e=1 sum=5",
               out_valid_a, out_err_a, out_sum_a);
    end
    tick();
`endif
    put(8'h80); put(8'h80); put(8'h80); put(8'h80);
    vectors++;
    if ({out_valid_a, out_err_a, out_sum_a} !== {1'b1, 1'b0, 8'd4}) begin
      errors++;
      $display("FAIL bubble_cleared: got v=%0b e=%0b sum=%0d want v=1 e=0 sum=4",
               out_valid_a, out_err_a, out_sum_a);
    end
    tick();
  endtask

  task automatic test_saturation;
    out_ready = 1'b1;
    put(8'hFF); put(8'hFF); put(8'hFF); put(8'hFF);
    vectors++;
    if ({out_valid_b, in_ready_b, out_sat_b, out_sum_b} !== {1'b1, 1'b0, 1'b1, 5'd31}) begin
      errors++;
      $display("FAIL sat_b: got v=%0b r=%0b s=%0b sum=%0d want v=1 r=0 s=1 sum=31",
               out_valid_b, in_ready_b, out_sat_b, out_sum_b);
    end
    vectors++;
    if ({out_sat_a, out_sum_a} !== {1'b0, 8'd32}) begin
      errors++;
      $display("FAIL sat_a_wide: got s=%0b sum=%0d want s=0 sum=32", out_sat_a, out_sum_a);
    end
    tick();
    put(8'hF0); put(8'hF0); put(8'hF0); put(8'hF0);
    vectors++;
    if ({out_valid_b, out_err_b, out_sat_b, out_sum_b} !== {1'b1, 1'b0, 1'b0, 5'd16}) begin
      errors++;
      $display("FAIL sat_cleared_b: got v=%0b e=%0b s=%0b sum=%0d want v=1 e=0 s=0 sum=16",
               out_valid_b, out_err_b, out_sat_b, out_sum_b);
    end
    tick();
    put(8'hFF); put(8'hFF); put(8'hFE); put(8'hFF);
    vectors++;
    if ({out_sat_b, out_sum_b, out_sat_a, out_sum_a} !== {1'b0, 5'd31, 1'b0, 8'd31}) begin
      errors++;
      $display("FAIL sat_exact_max: got b s=%0b sum=%0d a s=%0b sum=%0d want s=0 sum=31 both",
               out_sat_b, out_sum_b, out_sat_a, out_sum_a);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    put(8'hFF); put(8'hFF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({out_valid_a, in_ready_a, out_sum_a} !== {1'b0, 1'b1, 8'd0}) begin
      errors++;
      $display("FAIL rst_mid_state: got v=%0b r=%0b sum=%0d want v=0 r=1 sum=0",
               out_valid_a, in_ready_a, out_sum_a);
    end
    put(8'h80); put(8'h80); put(8'h80); put(8'h80);
    vectors++;
    if ({out_valid_a, out_err_a, out_sat_a, out_sum_a} !== {1'b1, 1'b0, 1'b0, 8'd4}) begin
      errors++;
      $display("FAIL rst_mid_window: got v=%0b e=%0b s=%0b sum=%0d want v=1 e=0 s=0 sum=4",
               out_valid_a, out_err_a, out_sat_a, out_sum_a);
    end
    tick();
    out_ready = 1'b0;
    put(8'hFF); put(8'hFF); put(8'hFF); put(8'hFF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({out_valid_a, in_ready_a, out_sum_a} !== {1'b0, 1'b1, 8'd0}) begin
      errors++;
      $display("FAIL rst_hold_state: got v=%0b r=%0b sum=%0d want v=0 r=1 sum=0",
               out_valid_a, in_ready_a, out_sum_a);
    end
    out_ready = 1'b1;
    put(8'h80); put(8'h80); put(8'h80); put(8'h80);
    vectors++;
    if ({out_valid_a, out_sat_b, out_sum_a} !== {1'b1, 1'b0, 8'd4}) begin
      errors++;
      $display("FAIL rst_hold_window: got v=%0b sat_b=%0b sum=%0d want v=1 sat_b=0 sum=4",
               out_valid_a, out_sat_b, out_sum_a);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_therm = 8'h00; out_ready = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_bubble();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/therm_accum.md
Name: therm_accum

Overview:
- Downstream consumer of the 8-bit thermometer-code sorter output.
- Decodes each thermometer word to a 4-bit count and checks it for bubbles.
- Accumulates WIN accepted samples into one windowed sum.
- Presents the sum to the next stage over a valid/ready handshake with sticky error and saturation flags.

Parameters:
- WIN, 16, samples per accumulation window; legal range 2..256.
- ACC_W, 8, accumulator/out_sum width; legal range 4..16.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_therm carries a sample
- in_ready  output  1  block accepts a sample this cycle
- in_therm  input  8  thermometer word; ones are packed from bit 7 downward
- out_valid  output  1  window result available
- out_ready  input  1  consumer takes the result
- out_sum  output  ACC_W  windowed sum of decoded counts
- out_err  output  1  at least one bubbled word occurred in the window
- out_sat  output  1  accumulator saturated during the window

Behaviour:
- Single clock domain. rst is synchronous and active-high and dominates every other input in the same cycle.
- Reset values: out_valid=0, out_sum=0, out_err=0, out_sat=0, in_ready=1, state=IDLE. Reset also clears the accumulator and the sample counter.
- Accept event: in_valid & in_ready on a clock edge. Nothing advances without an accept; in_valid gaps are allowed.
- Decode:
  - A word is legal iff it equals one of 00,80,C0,E0,F0,F8,FC,FE,FF (hex).
  - Legal word: value = number of ones (0..8).
  - Illegal word (bubble): value = popcount, and the window error flag is set.
- Accumulate: acc_next = acc + value, computed in ACC_W+1 bits. If the result exceeds 2^ACC_W-1, acc is clamped to 2^ACC_W-1 and the saturation flag is set. Once saturated, acc stays clamped.
- Sample counter: width clog2(WIN), counts accepts 0..WIN-1.
- States:
  - IDLE: in_ready=1. An accept loads acc=value, cnt=1 and moves to ACCUM.
  - ACCUM: in_ready=1. Each accept adds to acc and increments cnt. The accept that brings the total to WIN samples moves to HOLD.
  - HOLD: in_ready=0, out_valid=1. out_sum, out_err and out_sat are registered copies of the final window values and are held stable. When out_ready=1 the block clears acc, cnt and the flags and moves to IDLE; out_valid is 0 on the next cycle.
- Latency: out_valid rises on the clock edge after the WIN-th accept. Minimum window period is WIN+1 cycles; in_ready is low for at least 1 cycle per window.
- out_valid and all out_* outputs are registered. out_sum, out_err and out_sat are don't-care-free: they hold their last value outside HOLD until the next window completes, and are 0 after reset.
- out_valid never drops without out_ready while rst=0.
- Reset mid-window or during HOLD discards any partial sum and any pending result.
- WIN-sample boundary:
  - A bubble on the last sample is still flagged in that window's out_err.
  - Saturation on the last sample is flagged in that window's out_sat.

Optional Feature:
- Macro: THERM_ACCUM_STRICT_EN.
- Without the macro: a bubbled word is counted as popcount, contributes to the sum, advances cnt and sets out_err.
- With the macro:
  - A bubbled word is still accepted (in_ready unaffected) and sets out_err.
  - It contributes 0 to the sum and does not advance cnt, so the window needs WIN legal words.
  - out_valid timing is then measured from the WIN-th legal accept.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, in_therm=FF -> out_valid=0, out_sum=0, in_ready=1; no sample is counted.
- WIN=4: feed F0,F0,FF,80 back-to-back with out_ready=1 -> out_valid=1 exactly 1 cycle after the 4th accept, out_sum=17, out_err=0, out_sat=0; in_ready=1 again on the following cycle.
- Backpressure: complete a WIN=4 window with out_ready=0 for 10 cycles -> out_valid, out_sum and flags are stable and in_ready=0 throughout. Raising out_ready -> out_valid=0 and in_ready=1 the next cycle.
- Bubble: WIN=4, feed 80,A0,80,80.
  - Without the macro -> out_sum=5, out_err=1, result 1 cycle after the 4th accept.
  - With the macro -> no result until a 5th word 80 arrives; then out_sum=4, out_err=1.
- Saturation: ACC_W=5, WIN=4, feed FF×4 -> out_sum=31, out_sat=1. The next window F0×4 -> out_sum=16, out_sat=0.
- Reset mid-window: WIN=4, accept FF,FF, pulse rst for 1 cycle, then feed 80×4 -> out_sum=4, with no residue from the aborted window.
